// File: rtl/dut_mem_banked.sv
// Single-port word memory with byte enables, configurable read latency and an
// out-of-range error response; one transaction in flight at a time.
module dut_mem_banked #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sel,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACC  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BE_W-1:0]         be_q;
  logic [CNT_W-1:0]        cnt;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    ready_d;
  logic                    err_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Index truncation is safe: every access is gated by in_range.
  assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = IDX_W'(addr_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel) begin
          state_nxt = wr_rd ? WR_ACC : RD_WAIT;
        end
      end
      WR_ACC:  state_nxt = IDLE;
      RD_WAIT: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered below so ready/err/rdata are glitch-free
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if ((state == WR_ACC) || ((state == RD_WAIT) && (cnt == '0))) begin
      ready_d = 1'b1;
      err_d   = !in_range;
      if ((state == RD_WAIT) && in_range) begin
        rdata_d = mem[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= ready_d;
      err   <= err_d;
      rdata <= rdata_d;
    end
  end

  // Request capture and read-latency countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt     <= '0;
    end else if ((state == IDLE) && sel) begin
      addr_q <= addr;
      if (wr_rd) begin
        wdata_q <= wdata;
        be_q    <= be;
      end else begin
        cnt <= CNT_W'(RD_LATENCY - 1);
      end
    end else if ((state == RD_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage is not reset; a write commits only when leaving WR_ACC
  always_ff @(posedge clk) begin
    if ((state == WR_ACC) && in_range) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_mem_banked.sv
// Directed bench for dut_mem_banked: driver pushes expected completions into a
// scoreboard queue, a negedge monitor pops and checks them as ready appears.
module tb_dut_mem_banked;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 200;
  localparam int unsigned RDL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel;
  logic          wr_rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    be;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          err;

  typedef struct {
    time         t;
    logic [15:0] rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dut_mem_banked #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle either a completion matches the queue head, or outputs are quiet
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (ready) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready at %0t: rdata=%h err=%b, required no ready", $time, rdata, err);
      end else begin
        e = sb.pop_front();
        if ($time != e.t || rdata !== e.rd || err !== e.er) begin
          errors++;
          $display("FAIL completion at %0t: rdata=%h err=%b, required t=%0t rdata=%h err=%b",
                   $time, rdata, err, e.t, e.rd, e.er);
        end
      end
    end else if (rdata !== '0 || err !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_zero at %0t: ready=%b rdata=%h err=%b, required 0/0000/0",
               $time, ready, rdata, err);
    end
  end

  task automatic push_exp(input time t, input logic [15:0] rd, input logic er);
    exp_t e;
    e.t  = t;
    e.rd = rd;
    e.er = er;
    sb.push_back(e);
  endtask

  // Waits for a ready pulse on a negedge; drops sel there unless asked to hold it
  task automatic wait_ready(input string name, input bit keep_sel);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: ready=0, required ready within 12 cycles", name);
    end
    if (!keep_sel) sel = 1'b0;
  endtask

  task automatic txn(input string name, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [1:0] b,
                     input logic [15:0] exp_rd, input logic exp_err);
    @(negedge clk);
    sel = 1'b1; wr_rd = wr; addr = a; wdata = d; be = b;
    @(posedge clk);
    push_exp($time + (wr ? 10 : RDL * 10) + 5, exp_rd, exp_err);
    wait_ready(name, 1'b0);
  endtask

  initial begin
    time t1;
    reset_n = 1'b0;
    sel = 1'b1; wr_rd = 1'b1; addr = 8'h10; wdata = 16'hDEAD; be = 2'b11;
    // Reset held with a live request: nothing may be captured or signalled
    repeat (4) @(negedge clk);
    sel = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    txn("wr_10_full",   1'b1, 8'h10, 16'hA5A5, 2'b11, 16'h0000, 1'b0);
    txn("rd_10_full",   1'b0, 8'h10, 16'h0000, 2'b00, 16'hA5A5, 1'b0);
    txn("wr_10_lo",     1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000, 1'b0);
    txn("rd_10_merge",  1'b0, 8'h10, 16'h0000, 2'b00, 16'hA534, 1'b0);
    txn("wr_10_be0",    1'b1, 8'h10, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
    txn("rd_10_be0",    1'b0, 8'h10, 16'h0000, 2'b00, 16'hA534, 1'b0);
    txn("wr_10_hi",     1'b1, 8'h10, 16'h7700, 2'b10, 16'h0000, 1'b0);
    txn("rd_10_hi",     1'b0, 8'h10, 16'h0000, 2'b00, 16'h7734, 1'b0);

    // Out-of-range and last-valid-word boundary
    txn("wr_c7",        1'b1, 8'hC7, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
    txn("wr_f0_oor",    1'b1, 8'hF0, 16'h5555, 2'b11, 16'h0000, 1'b1);
    txn("rd_f0_oor",    1'b0, 8'hF0, 16'h0000, 2'b11, 16'h0000, 1'b1);
    txn("wr_c8_oor",    1'b1, 8'hC8, 16'h6666, 2'b11, 16'h0000, 1'b1);
    txn("rd_c7",        1'b0, 8'hC7, 16'h0000, 2'b00, 16'hBEEF, 1'b0);

    // Back-to-back reads with sel held across ready
    txn("wr_01",        1'b1, 8'h01, 16'h1111, 2'b11, 16'h0000, 1'b0);
    txn("wr_02",        1'b1, 8'h02, 16'h2222, 2'b11, 16'h0000, 1'b0);
    @(negedge clk);
    sel = 1'b1; wr_rd = 1'b0; addr = 8'h01; be = 2'b00;
    @(posedge clk);
    t1 = $time + RDL * 10 + 5;
    push_exp(t1, 16'h1111, 1'b0);
    push_exp(t1 + (RDL + 1) * 10, 16'h2222, 1'b0);
    wait_ready("b2b_first", 1'b1);
    addr = 8'h02;
    wait_ready("b2b_second", 1'b0);

    // Reset between capture and commit drops the write
    txn("wr_20_ones",   1'b1, 8'h20, 16'hFFFF, 2'b11, 16'h0000, 1'b0);
    @(negedge clk);
    sel = 1'b1; wr_rd = 1'b1; addr = 8'h20; wdata = 16'h0000; be = 2'b11;
    @(posedge clk);
    #1 reset_n = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    txn("rd_20_kept",   1'b0, 8'h20, 16'h0000, 2'b00, 16'hFFFF, 1'b0);

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
